// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC and the synchronous imem read port, and feeds
// decode through a 2-entry buffer. Credit-based issue, flush on redirect.
module fetch_sequencer #(
  parameter int              AW       = 32,
  parameter int              IW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_pc_plus4
);

  logic [AW-1:0]         fetch_pc_q, fetch_pc_d;
  logic                  infl_q, infl_d;
  logic [AW-1:0]         infl_pc_q, infl_pc_d;
  logic                  kill_q, kill_d;
  logic [1:0][IW-1:0]    buf_instr_q, buf_instr_d;
  logic [1:0][AW-1:0]    buf_pc_q, buf_pc_d;
  logic                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  pop, push, issue;

  always_comb begin
    pop   = (count_q != 2'd0) & out_ready;
    // Credit: buffered + in-flight entries, less the one leaving now, must stay below 2.
    issue = rst & ~redirect_valid &
            (({1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2);
    push  = infl_q & ~kill_q & ~redirect_valid;

    fetch_pc_d  = fetch_pc_q;
    infl_d      = issue;
    infl_pc_d   = infl_pc_q;
    kill_d      = kill_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};

    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push) begin
      buf_instr_d[wr_ptr_q] = imem_rdata;
      buf_pc_d[wr_ptr_q]    = infl_pc_q;
      wr_ptr_d              = ~wr_ptr_q;
    end

    if (issue) begin
      fetch_pc_d = fetch_pc_q + AW'(4);
      infl_pc_d  = fetch_pc_q;
      kill_d     = 1'b0;
    end else if (redirect_valid & infl_q) begin
      kill_d     = 1'b1;
    end

    // Redirect wins: the pop above still completes, everything else is flushed.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~AW'(3);
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      infl_q      <= 1'b0;
      infl_pc_q   <= '0;
      kill_q      <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      infl_q      <= infl_d;
      infl_pc_q   <= infl_pc_d;
      kill_q      <= kill_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  assign imem_req     = issue;
  assign imem_addr    = fetch_pc_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_instr    = buf_instr_q[rd_ptr_q];
  assign out_pc       = buf_pc_q[rd_ptr_q];
  assign out_pc_plus4 = out_pc + AW'(4);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && count_q == 2'd2));

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that sequences the program counter and the synchronous instruction memory, and hands fetched instructions to decode over a valid/ready handshake. It sits between the branch-resolution logic, which supplies redirects, and the decode stage. The PC register and the instruction-memory read port are both owned and driven by this block. A 2-entry fetch buffer, credit-based issue and flush-on-redirect provide back-to-back fetch with correct stall and branch behaviour.

## Interface
- AW, 32, address/PC width
- IW, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  AW  target PC; bits [1:0] ignored and forced to 0
- imem_req  output  1  instruction memory read enable this cycle
- imem_addr  output  AW  read address; valid when imem_req=1
- imem_rdata  input  IW  read data; valid in the cycle after the imem_req cycle
- out_valid  output  1  buffer head holds a valid instruction
- out_ready  input  1  decode accepts head this cycle
- out_instr  output  IW  head instruction
- out_pc  output  AW  PC of head instruction
- out_pc_plus4  output  AW  out_pc + 4, modulo 2^AW

## Operation
- State: fetch_pc; in-flight flag, in-flight PC and kill bit; 2-entry FIFO of {instr, pc}; occupancy count 0..2.
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, in-flight=0, kill=0, FIFO empty. Outputs: imem_req=0, out_valid=0, imem_addr=RESET_PC, out_instr=0, out_pc=0, out_pc_plus4=4.
- pop = out_valid & out_ready.
- Issue condition: !redirect_valid & (count + inflight - pop < 2). On issue: imem_req=1, imem_addr=fetch_pc, fetch_pc += 4 (wraps at 2^AW), in-flight set with PC captured and kill=0.
- Response: in the cycle after an issue, imem_rdata is pushed into the FIFO with its PC unless kill=1, in which case it is dropped. The in-flight flag clears unless a new issue occurs in the same cycle.
- Push and pop in the same cycle are legal at any occupancy the credit rule allows. The FIFO never overflows by construction; overflow is an assertion failure.
- Redirect (highest priority after reset): fetch_pc <= {redirect_pc[AW-1:2],2'b00}. FIFO is cleared after the pop (a handshake in the redirect cycle still completes). A response arriving in the redirect cycle is dropped. No issue occurs in the redirect cycle.
- Back-to-back redirects: the last one wins. Each redirect suppresses issue in its own cycle.
- Stall: with out_ready=0, the FIFO fills to 2 and imem_req drops to 0. Outputs stay stable while out_valid=1 & out_ready=0.

## Timing
- Cycle 0 = first rising edge after rst deasserts: imem_req=1, addr=RESET_PC. Data arrives in cycle 1 and is captured. out_valid=1 in cycle 2.
- Fetch-to-out latency: 2 cycles. Throughput: 1 instr/cycle with out_ready held high.
- Redirect sampled at cycle T:
  - imem_req=0 at T.
  - imem_req=1, addr=target at T+1.
  - out_valid at T+3 with out_pc=target.
  - out_valid=0 from T+1 until then.
- All outputs are registered or derived from registers, except imem_req, which depends on redirect_valid and out_ready.
- Reset asserted mid-operation clears all state immediately. A response arriving on the first post-reset cycle without a matching post-reset issue is ignored.

## Test plan
- Reset release, out_ready=1, memory returns instr=addr^32'hA5A5_0000 -> out_pc sequence 0,4,8,… on consecutive cycles from cycle 2; out_pc_plus4 = out_pc+4.
- out_ready=0 for 6 cycles after first out_valid -> FIFO holds PCs 0,4; imem_req low after 2 issues; release -> 0,4,8 delivered with no gap or duplicate.
- redirect_valid at T with target 0x100 while FIFO holds 2 entries and one fetch is in flight -> none of the old entries delivered after T; next out_pc=0x100 at T+3.
- Redirect with out_ready=1 in the same cycle -> head popped at T is counted as delivered; redirect_pc=0x103 fetches from 0x100.
- RESET_PC=0xFFFF_FFF8, free-run -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; out_pc_plus4 for 0xFFFF_FFFC is 0x0.
- rst pulsed low mid-stream with one fetch in flight -> out_valid=0 immediately; restart delivers RESET_PC first, with no stale instruction.
